// File: rtl/subbytes_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : subbytes_engine_if
//  Description : Handshake/data bundle for the AES SubBytes engine.
//                slave  = engine side, master = round-controller side.
//  Signals     : clear_i  synchronous flush
//                valid_i / ready_o / inv_i / state_i   input channel
//                valid_o / ready_i / state_o           output channel
//                done_o   one-cycle completion pulse
//                busy_o   substitution in progress
//  Revision    : 1.0 - initial release
// ============================================================================
interface subbytes_engine_if;
    logic         clear_i;
    logic         valid_i;
    logic         ready_o;
    logic         inv_i;
    logic [127:0] state_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] state_o;
    logic         done_o;
    logic         busy_o;

    modport slave (
        input  clear_i, valid_i, inv_i, state_i, ready_i,
        output ready_o, valid_o, state_o, done_o, busy_o
    );

    modport master (
        output clear_i, valid_i, inv_i, state_i, ready_i,
        input  ready_o, valid_o, state_o, done_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/subbytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : subbytes_engine
//  Description : AES SubBytes over the 128-bit state using NUM_SBOX
//                time-multiplexed S-box lanes (PASSES = 16/NUM_SBOX cycles
//                per state). Valid/ready on both sides.
//  Ports       : clk_i  clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    subbytes_engine_if.slave (handshake + data)
//  Option      : SUBBYTES_INV_EN - when defined, inverse S-box lanes are
//                built and inv_i selects the direction per transaction;
//                otherwise every transaction uses the forward S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
module subbytes_engine #(
    parameter int NUM_SBOX = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    subbytes_engine_if.slave        bus
);

    localparam int PASSES = 16 / NUM_SBOX;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("subbytes_engine: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    // Byte x of each table sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD[2047 - 8*int'(x) -: 8];
    endfunction

`ifdef SUBBYTES_INV_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV[2047 - 8*int'(x) -: 8];
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] pass_cnt;
    logic [127:0]     work;
    logic [127:0]     work_next;
    logic [127:0]     result;
    logic             done_q;
    logic             inv_q;
    logic             last_pass;
    logic             accept;
    int               base;
    logic [7:0]       lane_in  [NUM_SBOX];
    logic [7:0]       lane_out [NUM_SBOX];

    assign last_pass = (pass_cnt == CNT_W'(PASSES - 1));
    assign accept    = (fsm_q == IDLE) && bus.valid_i && !bus.clear_i;
    // First state byte handled by lane 0 in the current pass.
    assign base      = (PASSES == 1) ? 0 : int'(pass_cnt) * NUM_SBOX;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (accept)      fsm_d = SUB;
            SUB:     if (last_pass)   fsm_d = HOLD;
            HOLD:    if (bus.ready_i) fsm_d = IDLE;
            default:                  fsm_d = IDLE;
        endcase
        if (bus.clear_i) fsm_d = IDLE;
    end

    // ------------------------------------------------------------------
    // S-box lanes: lane k works on byte (base + k) of the working state
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_SBOX; k++)
            lane_in[k] = work[127 - 8*(base + k) -: 8];
    end

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
`ifdef SUBBYTES_INV_EN
        assign lane_out[k] = inv_q ? sbox_inv(lane_in[k]) : sbox_fwd(lane_in[k]);
`else
        assign lane_out[k] = sbox_fwd(lane_in[k]);
`endif
    end

`ifndef SUBBYTES_INV_EN
    logic unused_inv;
    assign unused_inv = bus.inv_i;
`endif

    always_comb begin
        work_next = work;
        for (int k = 0; k < NUM_SBOX; k++)
            work_next[127 - 8*(base + k) -: 8] = lane_out[k];
    end

    // ------------------------------------------------------------------
    // Datapath. result is a separate register so the consumer-visible
    // state only changes when a finished state lands, never mid-pass.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            work     <= '0;
            result   <= '0;
            done_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            done_q <= (fsm_q == SUB) && last_pass && !bus.clear_i;
            if (bus.clear_i) begin
                pass_cnt <= '0;
            end else if (accept) begin
                work     <= bus.state_i;
`ifdef SUBBYTES_INV_EN
                inv_q    <= bus.inv_i;
`endif
                pass_cnt <= '0;
            end else if (fsm_q == SUB) begin
                work     <= work_next;
                pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
                if (last_pass) result <= work_next;
            end
        end
    end

    // ready_o is forced low while reset is asserted.
    assign bus.ready_o = rst_n && (fsm_q == IDLE);
    assign bus.busy_o  = (fsm_q == SUB);
    assign bus.valid_o = (fsm_q == HOLD);
    assign bus.done_o  = done_q;
    assign bus.state_o = result;

endmodule
`default_nettype wire

// File: tb/tb_subbytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subbytes_engine
//  Description : Self-checking bench for subbytes_engine. Five engines with
//                NUM_SBOX = 16, 1, 4, 8, 2 share one clock and reset. Expected
//                results come from an S-box built from GF(2^8) arithmetic.
//                Compile with SUBBYTES_INV_EN to expect inverse behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subbytes_engine;

    localparam int NDUT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         clear_in [NDUT];
    logic         valid_in [NDUT];
    logic         inv_in   [NDUT];
    logic         ready_in [NDUT];
    logic [127:0] state_in [NDUT];
    wire          ready_out [NDUT];
    wire          valid_out [NDUT];
    wire          done_out  [NDUT];
    wire          busy_out  [NDUT];
    wire  [127:0] state_out [NDUT];

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   ftab [256];
    logic [7:0]   itab [256];
    logic [127:0] last_out [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LANES = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 8 : 2;
        subbytes_engine_if u_if ();
        assign u_if.clear_i = clear_in[g];
        assign u_if.valid_i = valid_in[g];
        assign u_if.inv_i   = inv_in[g];
        assign u_if.ready_i = ready_in[g];
        assign u_if.state_i = state_in[g];
        assign ready_out[g] = u_if.ready_o;
        assign valid_out[g] = u_if.valid_o;
        assign done_out[g]  = u_if.done_o;
        assign busy_out[g]  = u_if.busy_o;
        assign state_out[g] = u_if.state_o;
        subbytes_engine #(.NUM_SBOX(LANES)) u_dut (
            .clk_i (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );
    end

    // ---------------------------------------------------------------- model
    function automatic int lanes_of(input int d);
        case (d)
            0:       return 16;
            1:       return 1;
            2:       return 4;
            3:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] y, input int n);
        logic [15:0] t = {y, y};
        return t[15-n -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] y, s;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int c = 1; c < 256; c++)
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            ftab[x] = s;
            itab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        logic         use_inv;
`ifdef SUBBYTES_INV_EN
        use_inv = inv;
`else
        use_inv = 1'b0;
        if (inv) use_inv = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            b = s[127-8*i -: 8];
            r[127-8*i -: 8] = use_inv ? itab[b] : ftab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------------------------------------------------------- tasks
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++; if (ready_out[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 0", d, ready_out[d]); end
            checks++; if (valid_out[d] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b want 0", d, valid_out[d]); end
            checks++; if (done_out[d]  !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", d, done_out[d]); end
            checks++; if (busy_out[d]  !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_out[d]); end
            checks++; if (state_out[d] !== 128'h0) begin errors++; $display("FAIL reset_state dut%0d: got %h want 0", d, state_out[d]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++; if (ready_out[d] !== 1'b1) begin errors++; $display("FAIL post_reset_ready dut%0d: got %b want 1", d, ready_out[d]); end
            last_out[d] = 128'h0;
        end
    endtask

    // One full transaction on engine d; ready_i held low for 'hold' cycles
    // after valid_o rises.
    task automatic test_transaction(input int d, input logic [127:0] s, input logic inv,
                                    input int hold, input string tag);
        int           p = 16 / lanes_of(d);
        logic [127:0] expv = model(s, inv);
        int           n = 0;
        int           busy_n = 0;
        int           early = 0;
        ready_in[d] = (hold == 0);
        while (ready_out[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (ready_out[d] !== 1'b1) begin errors++; $display("FAIL %s_ready dut%0d: got %b want 1", tag, d, ready_out[d]); end
        valid_in[d] = 1'b1; state_in[d] = s; inv_in[d] = inv;
        @(negedge clk);
        valid_in[d] = 1'b0; state_in[d] = rand128(); inv_in[d] = ~inv;
        n = 0;
        while (valid_out[d] !== 1'b1 && n < 100) begin
            if (busy_out[d] === 1'b1) busy_n++;
            if (done_out[d] === 1'b1) early++;
            @(negedge clk); n++;
        end
        checks++; if (n != p) begin errors++; $display("FAIL %s_latency dut%0d: got %0d want %0d", tag, d, n, p); end
        checks++; if (busy_n != p) begin errors++; $display("FAIL %s_busy_cycles dut%0d: got %0d want %0d", tag, d, busy_n, p); end
        checks++; if (early != 0) begin errors++; $display("FAIL %s_early_done dut%0d: got %0d want 0", tag, d, early); end
        checks++; if (done_out[d] !== 1'b1) begin errors++; $display("FAIL %s_done dut%0d: got %b want 1", tag, d, done_out[d]); end
        checks++; if (ready_out[d] !== 1'b0) begin errors++; $display("FAIL %s_hold_ready dut%0d: got %b want 0", tag, d, ready_out[d]); end
        checks++; if (state_out[d] !== expv) begin errors++; $display("FAIL %s_result dut%0d: got %h want %h", tag, d, state_out[d], expv); end
        last_out[d] = expv;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            checks++; if (valid_out[d] !== 1'b1) begin errors++; $display("FAIL %s_bp_valid dut%0d: got %b want 1", tag, d, valid_out[d]); end
            checks++; if (done_out[d] !== 1'b0) begin errors++; $display("FAIL %s_bp_done dut%0d: got %b want 0", tag, d, done_out[d]); end
            checks++; if (ready_out[d] !== 1'b0) begin errors++; $display("FAIL %s_bp_ready dut%0d: got %b want 0", tag, d, ready_out[d]); end
            checks++; if (state_out[d] !== expv) begin errors++; $display("FAIL %s_bp_state dut%0d: got %h want %h", tag, d, state_out[d], expv); end
        end
        ready_in[d] = 1'b1;
        @(negedge clk);
        checks++; if (valid_out[d] !== 1'b0) begin errors++; $display("FAIL %s_consumed_valid dut%0d: got %b want 0", tag, d, valid_out[d]); end
        checks++; if (ready_out[d] !== 1'b1) begin errors++; $display("FAIL %s_idle_ready dut%0d: got %b want 1", tag, d, ready_out[d]); end
        checks++; if (done_out[d] !== 1'b0) begin errors++; $display("FAIL %s_done_once dut%0d: got %b want 0", tag, d, done_out[d]); end
        checks++; if (state_out[d] !== expv) begin errors++; $display("FAIL %s_retain dut%0d: got %h want %h", tag, d, state_out[d], expv); end
    endtask

    task automatic test_known_vector();
        test_transaction(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0, "fips_n16");
        checks++; if (state_out[0] !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL fips_n16_const: got %h want d42711aee0bf98f1b8b45de51e415230", state_out[0]); end
        test_transaction(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0, "fips_n1");
        checks++; if (state_out[1] !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL fips_n1_const: got %h want d42711aee0bf98f1b8b45de51e415230", state_out[1]); end
    endtask

    task automatic test_inverse();
        logic [127:0] zero_inv_exp;
`ifdef SUBBYTES_INV_EN
        zero_inv_exp = {16{8'h52}};
`else
        zero_inv_exp = {16{8'h63}};
`endif
        test_transaction(2, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 0, "inv_n4");
        test_transaction(2, 128'h0, 1'b0, 0, "zero_fwd");
        checks++; if (state_out[2] !== {16{8'h63}}) begin errors++; $display("FAIL zero_fwd_const: got %h want %h", state_out[2], {16{8'h63}}); end
        test_transaction(2, 128'h0, 1'b1, 0, "zero_inv");
        checks++; if (state_out[2] !== zero_inv_exp) begin errors++; $display("FAIL zero_inv_const: got %h want %h", state_out[2], zero_inv_exp); end
    endtask

    task automatic test_random();
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 2; i++)
                test_transaction(d, rand128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_backpressure();
        test_transaction(3, rand128(), 1'b0, 10, "bp_n8");
        test_transaction(3, rand128(), 1'($urandom_range(0, 1)), 0, "after_bp");
    endtask

    task automatic test_clear();
        int seen_valid = 0;
        ready_in[4] = 1'b1;
        valid_in[4] = 1'b1; state_in[4] = rand128(); inv_in[4] = 1'b0;
        @(negedge clk);
        valid_in[4] = 1'b0;
        repeat (3) @(negedge clk);
        clear_in[4] = 1'b1;
        @(negedge clk);
        clear_in[4] = 1'b0;
        checks++; if (ready_out[4] !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", ready_out[4]); end
        checks++; if (busy_out[4] !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy_out[4]); end
        checks++; if (state_out[4] !== last_out[4]) begin errors++; $display("FAIL clear_state: got %h want %h", state_out[4], last_out[4]); end
        repeat (10) begin
            if (valid_out[4] !== 1'b0 || done_out[4] !== 1'b0) seen_valid++;
            @(negedge clk);
        end
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL clear_no_valid: got %0d want 0", seen_valid); end
        valid_in[4] = 1'b1; clear_in[4] = 1'b1; state_in[4] = rand128();
        @(negedge clk);
        valid_in[4] = 1'b0; clear_in[4] = 1'b0;
        checks++; if (busy_out[4] !== 1'b0) begin errors++; $display("FAIL clear_drop_busy: got %b want 0", busy_out[4]); end
        checks++; if (ready_out[4] !== 1'b1) begin errors++; $display("FAIL clear_drop_ready: got %b want 1", ready_out[4]); end
        test_transaction(4, rand128(), 1'($urandom_range(0, 1)), 0, "after_clear");
    endtask

    task automatic test_async_reset();
        ready_in[2] = 1'b0; ready_in[4] = 1'b1;
        valid_in[2] = 1'b1; state_in[2] = rand128();
        valid_in[4] = 1'b1; state_in[4] = rand128();
        @(negedge clk);
        valid_in[2] = 1'b0; valid_in[4] = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (valid_out[2] !== 1'b1) begin errors++; $display("FAIL pre_rst_hold dut2: got %b want 1", valid_out[2]); end
        checks++; if (busy_out[4] !== 1'b1) begin errors++; $display("FAIL pre_rst_sub dut4: got %b want 1", busy_out[4]); end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 2; d < NDUT; d += 2) begin
            checks++; if (ready_out[d] !== 1'b0) begin errors++; $display("FAIL arst_ready dut%0d: got %b want 0", d, ready_out[d]); end
            checks++; if (valid_out[d] !== 1'b0) begin errors++; $display("FAIL arst_valid dut%0d: got %b want 0", d, valid_out[d]); end
            checks++; if (busy_out[d] !== 1'b0) begin errors++; $display("FAIL arst_busy dut%0d: got %b want 0", d, busy_out[d]); end
            checks++; if (done_out[d] !== 1'b0) begin errors++; $display("FAIL arst_done dut%0d: got %b want 0", d, done_out[d]); end
            checks++; if (state_out[d] !== 128'h0) begin errors++; $display("FAIL arst_state dut%0d: got %h want 0", d, state_out[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready_in[2] = 1'b1;
        for (int d = 0; d < NDUT; d++) last_out[d] = 128'h0;
        @(negedge clk);
        test_transaction(4, rand128(), 1'b0, 0, "post_arst_n2");
        test_transaction(2, rand128(), 1'b1, 0, "post_arst_n4");
    endtask

    task automatic test_back_to_back();
        logic [127:0] q[$];
        logic [127:0] expv;
        int           last_acc = -1;
        int           accepts = 0;
        ready_in[3] = 1'b1;
        valid_in[3] = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (valid_out[3] === 1'b1 && done_out[3] === 1'b1) begin
                expv = (q.size() > 0) ? q.pop_front() : 128'hx;
                checks++; if (state_out[3] !== expv) begin errors++; $display("FAIL b2b_result: got %h want %h", state_out[3], expv); end
            end
            if (cyc < 40) begin
                state_in[3] = rand128();
                inv_in[3]   = 1'($urandom_range(0, 1));
                if (ready_out[3] === 1'b1) begin
                    if (last_acc >= 0) begin
                        checks++; if (cyc - last_acc != 4) begin errors++; $display("FAIL b2b_interval: got %0d want 4", cyc - last_acc); end
                    end
                    last_acc = cyc;
                    accepts++;
                    q.push_back(model(state_in[3], inv_in[3]));
                end
            end else begin
                valid_in[3] = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending want 0", q.size()); end
        checks++; if (accepts < 9) begin errors++; $display("FAIL b2b_accepts: got %0d want >= 9", accepts); end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        for (int d = 0; d < NDUT; d++) begin
            clear_in[d] = 1'b0; valid_in[d] = 1'b0; inv_in[d] = 1'b0;
            ready_in[d] = 1'b1; state_in[d] = 128'h0; last_out[d] = 128'h0;
        end
        build_tables();
        test_reset();
        test_known_vector();
        test_inverse();
        test_random();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/subbytes_engine.md
Name: subbytes_engine

Overview:
Parametrised AES SubBytes engine for the 128-bit cipher state, replacing the fixed 16-S-box, single-cycle stage.
- NUM_SBOX S-box lanes are time-multiplexed over the 16 state bytes, trading area for latency.
- Valid/ready handshake on both sides; optional inverse S-box for decryption.
- Sits between the round controller and ShiftRows in the round datapath.

Parameters:
NUM_SBOX, 16, number of S-box lanes; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
PASSES, 16/NUM_SBOX, derived (localparam), cycles needed per state.

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous flush; aborts any operation, returns to IDLE
valid_i  in  1  input state valid
ready_o  out  1  engine can accept a state
inv_i  in  1  1 = inverse SubBytes; sampled with state_i
state_i  in  128  input state, byte 0 = [127:120] ... byte 15 = [7:0]
valid_o  out  1  result valid, held until accepted
ready_i  in  1  downstream accepts result
state_o  out  128  substituted state
done_o  out  1  one-cycle pulse on the cycle valid_o first rises
busy_o  out  1  high in SUB state

Behaviour:
- Reset values: ready_o=0 during reset, valid_o=0, done_o=0, busy_o=0, state_o=0. FSM=IDLE, pass counter=0, working register=0. After reset, ready_o=1 (IDLE).
- FSM states: IDLE, SUB, HOLD.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: capture state_i into the working register, latch inv_i, set counter=0, go to SUB.
- SUB:
  - ready_o=0, busy_o=1.
  - Each cycle, lane k substitutes byte (counter*NUM_SBOX + k) in the working register, in place; all other bytes are unchanged.
  - Counter increments per cycle, width max(1,$clog2(PASSES)).
  - On the cycle with counter==PASSES-1: write the final bytes, go to HOLD, and assert valid_o and done_o at the next edge.
- HOLD:
  - valid_o=1; state_o equals the working register and is stable.
  - done_o is high only on the first HOLD cycle.
  - On ready_i: go to IDLE, and valid_o drops next cycle.
  - No new input is accepted in the same cycle (ready_o=0 in HOLD).
- Latency: accept edge N gives valid_o high after edge N+PASSES. NUM_SBOX=16 gives 1 cycle. Minimum initiation interval is PASSES+2 cycles with ready_i tied high.
- state_o retains the last result after consumption, until the next result lands.
- Substitution uses the forward S-box if latched inv=0, otherwise the inverse S-box. Both are combinational per lane.
- clear_i has priority over all transitions:
  - Next cycle: FSM=IDLE, valid_o=0, done_o=0, busy_o=0, counter=0.
  - state_o/working register are not cleared.
  - clear_i together with valid_i in IDLE: the input is dropped.
- valid_i or state_i changing while not ready_o is ignored.
- inv_i is sampled only at acceptance.
- Async reset mid-SUB or mid-HOLD: all outputs go to their reset values immediately. The in-flight state is lost.

Optional Feature:
SUBBYTES_INV_EN
- Defined: inverse S-box lanes are instantiated and inv_i selects forward or inverse per transaction.
- Undefined: no inverse S-box logic is instantiated; inv_i is ignored (tie-off allowed) and all transactions use the forward S-box.

Test Plan:
- NUM_SBOX=16:
  - Stimulus: state_i=193de3bea0f4e22b9ac68d2ae9f84808, inv_i=0, ready_i=1.
  - Response: valid_o and done_o high 1 cycle after acceptance; state_o=d42711aee0bf98f1b8b45de51e415230.
- NUM_SBOX=1, same vector:
  - Response: busy_o high 16 cycles; valid_o 16 cycles after acceptance; same result; done_o high for exactly 1 cycle.
- SUBBYTES_INV_EN defined, NUM_SBOX=4:
  - Stimulus: state_i=d42711aee0bf98f1b8b45de51e415230, inv_i=1.
  - Response: state_o=193de3bea0f4e22b9ac68d2ae9f84808 after 4 cycles.
  - Byte check: 00..00 with inv=0 gives 6363...63; with inv=1 gives 5252...52.
- Backpressure, NUM_SBOX=8:
  - Stimulus: ready_i=0 for 10 cycles after valid_o rises.
  - Response: valid_o and state_o stable, done_o pulses once, ready_o=0 throughout. ready_i=1 gives IDLE next cycle, then accepts a new state.
- Flush and reset, NUM_SBOX=2:
  - clear_i at pass 3: valid_o never rises, ready_o=1 next cycle, a new vector completes correctly.
  - Repeat with rst_n low mid-SUB: all outputs immediately 0; post-reset transaction correct.
